regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-bank write port between two requesters:
  - the in-order pipeline writeback (ALU/load results);
  - the multi-cycle multiply/divide unit (MDU).
- Holds one colliding MDU result in a pending register.
- Tracks in-flight MDU destinations in a scoreboard so the decode stage can detect RAW hazards.
- Forces a pipeline stall when a pending MDU result has been starved for too long.
- Sits between the execute/writeback stages and the register bank's write port, beside decode.

Parameters:
- WORD_WIDTH, 32, data width of register-bank write data.
- ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers).
- MAX_WAIT, 4, cycles a pending MDU result may lose arbitration before a forced stall (legal range 1..15).

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid_i  in  1  pipeline writeback request.
- wb_addr_i  in  ADDR_WIDTH  pipeline destination register.
- wb_data_i  in  WORD_WIDTH  pipeline writeback data.
- wb_ready_o  out  1  pipeline writeback accepted this cycle.
- mdu_issue_i  in  1  MDU operation issued this cycle; marks the destination busy.
- mdu_issue_rd_i  in  ADDR_WIDTH  destination of the issued MDU operation.
- mdu_valid_i  in  1  MDU result valid.
- mdu_rd_i  in  ADDR_WIDTH  MDU result destination.
- mdu_data_i  in  WORD_WIDTH  MDU result data.
- mdu_ready_o  out  1  MDU result accepted this cycle.
- rs1_addr_i  in  ADDR_WIDTH  decode source register 1.
- rs2_addr_i  in  ADDR_WIDTH  decode source register 2.
- hazard_o  out  1  a decode source is busy in the scoreboard.
- reg_wen_o  out  1  register-bank write enable.
- reg_waddr_o  out  ADDR_WIDTH  register-bank write address.
- reg_wdata_o  out  WORD_WIDTH  register-bank write data.
- stall_o  out  1  freeze request to the pipeline.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pending empty, wait counter=0, scoreboard all clear.
  - stall_o=0, reg_wen_o=0, hazard_o=0.
  - wb_ready_o=1, mdu_ready_o=1.
- Reset asserted mid-operation discards any pending result; its busy bit is cleared.
- Write-port outputs are combinational from state and inputs. The bank commits on the next clk edge, so writeback latency is zero cycles.
- Any write to address 0 completes its handshake but drives reg_wen_o=0.
- FSM:
  - IDLE:
    - wb_ready_o=1, mdu_ready_o=1.
    - wb_valid only: write wb.
    - mdu_valid only: write MDU directly.
    - Both valid: write wb, capture MDU rd/data into pending, counter=0, go to PEND.
  - PEND:
    - mdu_ready_o=0.
    - !wb_valid_i: write pending, go to IDLE.
    - wb_valid_i: write wb, counter+1. When counter reaches MAX_WAIT, go to FORCE.
  - FORCE:
    - stall_o=1, wb_ready_o=0, mdu_ready_o=0.
    - Write pending, go to IDLE.
    - stall_o is high for exactly one cycle per FORCE entry.
- Priority: pipeline writeback beats a new or pending MDU result, except in FORCE.
- Scoreboard (one busy bit per register; register 0 is never busy):
  - Set on mdu_issue_i for mdu_issue_rd_i.
  - Cleared in the cycle the corresponding MDU result is written, whether direct or from pending.
  - Set and clear of the same register in the same cycle: set wins.
- hazard_o = busy[rs1_addr_i] | busy[rs2_addr_i]. It is combinational and reflects the registered busy bits only; there is no same-cycle bypass of an issue.
- The pipeline must not write back to a register that is busy. The arbiter does not check this.

Optional Feature:
- Macro: ARB_STALL_COUNT_EN.
- Defined:
  - Adds output stall_count_o [15:0], a saturating count of FORCE entries.
  - Reset value 0; increments on each entry to FORCE; holds at 16'hFFFF.
- Not defined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 mid-PEND, release -> reg_wen_o=0, stall_o=0, hazard_o=0, mdu_ready_o=1; the pending write never appears.
- Collision:
  - Stimulus: wb (x5, 0x11) and MDU (x6, 0x22) valid in the same cycle, then wb idle.
  - Required: cycle0 writes x5=0x11; cycle1 writes x6=0x22; mdu_ready_o=0 in cycle1 only; state returns to IDLE.
- Starvation with MAX_WAIT=4:
  - Stimulus: collision followed by continuous wb_valid.
  - Required: 4 further wb writes, then stall_o=1 and wb_ready_o=0 for one cycle while pending is written; the wb write resumes the next cycle.
- Scoreboard:
  - Stimulus: mdu_issue_i to x7, then rs1_addr_i=7; later the MDU result for x7 is written.
  - Required: hazard_o=1 from the cycle after issue until the write cycle; 0 on the following cycle.
  - Also: issuing to x0 never raises hazard_o.
- x0 and simultaneous set/clear:
  - MDU result to x0 -> reg_wen_o=0, mdu handshake completes.
  - Issue to x9 in the same cycle x9's old result is written -> x9 stays busy.
- With ARB_STALL_COUNT_EN: 3 forced stalls -> stall_count_o=3.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-bank write-port arbiter between pipeline writeback and the MDU,
// with a one-entry pending buffer, starvation stall and RAW scoreboard.
// Optional: define ARB_STALL_COUNT_EN to add a saturating forced-stall counter.
module regfile_wb_arbiter #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_valid_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WORD_WIDTH-1:0] wb_data_i,
    output logic                  wb_ready_o,
    input  logic                  mdu_issue_i,
    input  logic [ADDR_WIDTH-1:0] mdu_issue_rd_i,
    input  logic                  mdu_valid_i,
    input  logic [ADDR_WIDTH-1:0] mdu_rd_i,
    input  logic [WORD_WIDTH-1:0] mdu_data_i,
    output logic                  mdu_ready_o,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    output logic                  hazard_o,
    output logic                  reg_wen_o,
    output logic [ADDR_WIDTH-1:0] reg_waddr_o,
    output logic [WORD_WIDTH-1:0] reg_wdata_o,
    output logic                  stall_o
`ifdef ARB_STALL_COUNT_EN
    ,
    output logic [15:0]           stall_count_o
`endif
);

    localparam int         NUM_REGS   = 1 << ADDR_WIDTH;
    localparam logic [3:0] MAX_WAIT_W = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_FORCE
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              wait_q, wait_d;
    logic [ADDR_WIDTH-1:0]   pend_rd_q;
    logic [WORD_WIDTH-1:0]   pend_data_q;
    logic [NUM_REGS-1:0]     busy_q, busy_d;

    logic                    capture;
    logic                    sel_valid;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [WORD_WIDTH-1:0]   sel_data;
    logic                    mdu_write;
    logic [ADDR_WIDTH-1:0]   mdu_write_rd;

    assign capture = (state_q == S_IDLE) && wb_valid_i && mdu_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            pend_rd_q <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            busy_q    <= busy_d;
            if (capture) pend_rd_q <= mdu_rd_i;
        end
    end

    // NOTE: pending data is only read when state says it is valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture) pend_data_q <= mdu_data_i;
    end

    // NOTE: combinational blocks use blocking assignments with defaults first, so no latches.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_IDLE: begin
                if (wb_valid_i && mdu_valid_i) begin
                    state_d = S_PEND;
                    wait_d  = '0;
                end
            end
            S_PEND: begin
                if (!wb_valid_i) begin
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + 4'd1;
                    if (wait_d == MAX_WAIT_W) state_d = S_FORCE;
                end
            end
            S_FORCE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wb_ready_o   = 1'b1;
        mdu_ready_o  = 1'b1;
        stall_o      = 1'b0;
        sel_valid    = 1'b0;
        sel_addr     = '0;
        sel_data     = '0;
        mdu_write    = 1'b0;
        mdu_write_rd = '0;
        unique case (state_q)
            S_IDLE: begin
                if (wb_valid_i) begin
                    sel_valid = 1'b1;
                    sel_addr  = wb_addr_i;
                    sel_data  = wb_data_i;
                end else if (mdu_valid_i) begin
                    sel_valid    = 1'b1;
                    sel_addr     = mdu_rd_i;
                    sel_data     = mdu_data_i;
                    mdu_write    = 1'b1;
                    mdu_write_rd = mdu_rd_i;
                end
            end
            S_PEND: begin
                mdu_ready_o = 1'b0;
                sel_valid   = 1'b1;
                if (wb_valid_i) begin
                    sel_addr = wb_addr_i;
                    sel_data = wb_data_i;
                end else begin
                    sel_addr     = pend_rd_q;
                    sel_data     = pend_data_q;
                    mdu_write    = 1'b1;
                    mdu_write_rd = pend_rd_q;
                end
            end
            S_FORCE: begin
                stall_o      = 1'b1;
                wb_ready_o   = 1'b0;
                mdu_ready_o  = 1'b0;
                sel_valid    = 1'b1;
                sel_addr     = pend_rd_q;
                sel_data     = pend_data_q;
                mdu_write    = 1'b1;
                mdu_write_rd = pend_rd_q;
            end
            default: ;
        endcase
    end

    // Writes to x0 still complete their handshake but never reach the bank.
    assign reg_wen_o   = sel_valid && (sel_addr != '0);
    assign reg_waddr_o = sel_addr;
    assign reg_wdata_o = sel_data;

    // Set is applied after clear so an issue wins over a same-cycle retire.
    always_comb begin
        busy_d = busy_q;
        if (mdu_write) busy_d[mdu_write_rd] = 1'b0;
        if (mdu_issue_i) busy_d[mdu_issue_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    assign hazard_o = busy_q[rs1_addr_i] | busy_q[rs2_addr_i];

`ifdef ARB_STALL_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_o <= '0;
        end else if (state_d == S_FORCE && state_q != S_FORCE && stall_count_o != 16'hFFFF) begin
            stall_count_o <= stall_count_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (MAX_WAIT=4);
// define ARB_STALL_COUNT_EN to also exercise the forced-stall counter.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wb_valid_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        wb_ready_o;
    logic        mdu_issue_i;
    logic [4:0]  mdu_issue_rd_i;
    logic        mdu_valid_i;
    logic [4:0]  mdu_rd_i;
    logic [31:0] mdu_data_i;
    logic        mdu_ready_o;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        hazard_o;
    logic        reg_wen_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        stall_o;
`ifdef ARB_STALL_COUNT_EN
    logic [15:0] stall_count_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_arbiter #(
        .WORD_WIDTH(32),
        .ADDR_WIDTH(5),
        .MAX_WAIT  (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_valid_i    (wb_valid_i),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i),
        .wb_ready_o    (wb_ready_o),
        .mdu_issue_i   (mdu_issue_i),
        .mdu_issue_rd_i(mdu_issue_rd_i),
        .mdu_valid_i   (mdu_valid_i),
        .mdu_rd_i      (mdu_rd_i),
        .mdu_data_i    (mdu_data_i),
        .mdu_ready_o   (mdu_ready_o),
        .rs1_addr_i    (rs1_addr_i),
        .rs2_addr_i    (rs2_addr_i),
        .hazard_o      (hazard_o),
        .reg_wen_o     (reg_wen_o),
        .reg_waddr_o   (reg_waddr_o),
        .reg_wdata_o   (reg_wdata_o),
        .stall_o       (stall_o)
`ifdef ARB_STALL_COUNT_EN
        ,
        .stall_count_o (stall_count_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        wb_valid_i  = wv;
        wb_addr_i   = wa;
        wb_data_i   = wd;
        mdu_valid_i = mv;
        mdu_rd_i    = ma;
        mdu_data_i  = md;
    endtask

    task automatic expect_write(input string tag, input logic wen, input logic [4:0] addr, input logic [31:0] data);
        check({tag, "_wen"}, 64'(reg_wen_o), 64'(wen));
        if (wen) begin
            check({tag, "_waddr"}, 64'(reg_waddr_o), 64'(addr));
            check({tag, "_wdata"}, 64'(reg_wdata_o), 64'(data));
        end
    endtask

    // Collision on x1/x2, then continuous wb until the forced stall drains pending.
    task automatic starve();
        drive(1'b1, 5'd1, 32'hA0, 1'b1, 5'd2, 32'hB0);
        #1;
        expect_write("starve_c0", 1'b1, 5'd1, 32'hA0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'd1, 32'hA0 + 32'(i), 1'b0, 5'd0, 32'h0);
            #1;
            expect_write("starve_wb", 1'b1, 5'd1, 32'hA0 + 32'(i));
            check("starve_stall_low", 64'(stall_o), 64'd0);
            check("starve_mdu_ready", 64'(mdu_ready_o), 64'd0);
            tick();
        end
        drive(1'b1, 5'd1, 32'hA5, 1'b0, 5'd0, 32'h0);
        #1;
        check("force_stall", 64'(stall_o), 64'd1);
        check("force_wb_ready", 64'(wb_ready_o), 64'd0);
        expect_write("force_pend", 1'b1, 5'd2, 32'hB0);
        tick();
        #1;
        check("resume_stall", 64'(stall_o), 64'd0);
        check("resume_wb_ready", 64'(wb_ready_o), 64'd1);
        expect_write("resume_wb", 1'b1, 5'd1, 32'hA5);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
    endtask

    initial begin
        rst_n          = 1'b0;
        mdu_issue_i    = 1'b0;
        mdu_issue_rd_i = '0;
        rs1_addr_i     = '0;
        rs2_addr_i     = '0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("rst_wb_ready", 64'(wb_ready_o), 64'd1);
        check("rst_mdu_ready", 64'(mdu_ready_o), 64'd1);
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_wen", 64'(reg_wen_o), 64'd0);
        check("rst_hazard", 64'(hazard_o), 64'd0);
`ifdef ARB_STALL_COUNT_EN
        check("rst_stall_count", 64'(stall_count_o), 64'd0);
`endif
        tick();
        tick();
        rst_n = 1'b1;

        // Collision: x5 from wb, x6 from MDU, then wb idle
        drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22);
        #1;
        expect_write("col_c0", 1'b1, 5'd5, 32'h11);
        check("col_c0_wb_ready", 64'(wb_ready_o), 64'd1);
        check("col_c0_mdu_ready", 64'(mdu_ready_o), 64'd1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        expect_write("col_c1", 1'b1, 5'd6, 32'h22);
        check("col_c1_mdu_ready", 64'(mdu_ready_o), 64'd0);
        check("col_c1_stall", 64'(stall_o), 64'd0);
        tick();
        #1;
        expect_write("col_c2", 1'b0, 5'd0, 32'h0);
        check("col_c2_mdu_ready", 64'(mdu_ready_o), 64'd1);

        // Starvation and forced stall
        starve();
`ifdef ARB_STALL_COUNT_EN
        check("stall_count_1", 64'(stall_count_o), 64'd1);
        starve();
        starve();
        check("stall_count_3", 64'(stall_count_o), 64'd3);
`endif

        // Scoreboard: issue x7, hazard visible from next cycle until write
        mdu_issue_i    = 1'b1;
        mdu_issue_rd_i = 5'd7;
        rs1_addr_i     = 5'd7;
        #1;
        check("sb_no_bypass", 64'(hazard_o), 64'd0);
        tick();
        mdu_issue_i = 1'b0;
        #1;
        check("sb_busy_c1", 64'(hazard_o), 64'd1);
        tick();
        #1;
        check("sb_busy_c2", 64'(hazard_o), 64'd1);
        rs1_addr_i = 5'd0;
        rs2_addr_i = 5'd7;
        #1;
        check("sb_busy_rs2", 64'(hazard_o), 64'd1);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77);
        #1;
        check("sb_write_cycle", 64'(hazard_o), 64'd1);
        expect_write("sb_mdu_direct", 1'b1, 5'd7, 32'h77);
        check("sb_mdu_ready", 64'(mdu_ready_o), 64'd1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("sb_cleared", 64'(hazard_o), 64'd0);
        rs2_addr_i = 5'd0;

        // Issue to x0 never marks busy
        mdu_issue_i    = 1'b1;
        mdu_issue_rd_i = 5'd0;
        tick();
        mdu_issue_i = 1'b0;
        #1;
        check("sb_x0_issue", 64'(hazard_o), 64'd0);

        // Writes to x0 complete the handshake without a bank write
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
        #1;
        check("x0_mdu_wen", 64'(reg_wen_o), 64'd0);
        check("x0_mdu_ready", 64'(mdu_ready_o), 64'd1);
        tick();
        drive(1'b1, 5'd0, 32'h66, 1'b0, 5'd0, 32'h0);
        #1;
        check("x0_wb_wen", 64'(reg_wen_o), 64'd0);
        check("x0_wb_ready", 64'(wb_ready_o), 64'd1);
        tick();

        // Same-cycle set and clear of x9: set wins
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        mdu_issue_i    = 1'b1;
        mdu_issue_rd_i = 5'd9;
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
        #1;
        expect_write("sc_x9_write", 1'b1, 5'd9, 32'h99);
        tick();
        mdu_issue_i = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rs1_addr_i = 5'd9;
        #1;
        check("sc_x9_still_busy", 64'(hazard_o), 64'd1);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9A);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("sc_x9_cleared", 64'(hazard_o), 64'd0);

        // Reset mid-PEND discards pending result and its busy bit
        mdu_issue_i    = 1'b1;
        mdu_issue_rd_i = 5'd12;
        tick();
        mdu_issue_i = 1'b0;
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd12, 32'hCC);
        tick();
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rs1_addr_i = 5'd12;
        #1;
        check("mid_rst_mdu_ready", 64'(mdu_ready_o), 64'd1);
        check("mid_rst_wen", 64'(reg_wen_o), 64'd0);
        check("mid_rst_hazard", 64'(hazard_o), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_wen", 64'(reg_wen_o), 64'd0);
        check("post_rst_stall", 64'(stall_o), 64'd0);
        check("post_rst_hazard", 64'(hazard_o), 64'd0);
        check("post_rst_mdu_ready", 64'(mdu_ready_o), 64'd1);
`ifdef ARB_STALL_COUNT_EN
        check("post_rst_stall_count", 64'(stall_count_o), 64'd0);
`endif
        tick();
        #1;
        check("post_rst_no_pend_write", 64'(reg_wen_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
